// File: rtl/multu_hilo_32bits.sv
// multu_hilo_32bits: 32x32 unsigned shift-add multiplier with HI/LO registers and MFHI/MFLO read-back
module multu_hilo_32bits #(
  parameter logic [5:0] MULTU = 6'b011001,
  parameter logic [5:0] MFHI  = 6'b010000,
  parameter logic [5:0] MFLO  = 6'b010010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [5:0]  signal,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] out
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [63:0] mcand_q, mcand_d, prod_q, prod_d, sum;
  logic [31:0] mplr_q, mplr_d, hi_q, hi_d, lo_q, lo_d;
  logic [5:0] cnt_q, cnt_d;
  logic done_q, done_d, launch, run, last;
  always_comb begin
    run = state_q == RUN;
    launch = state_q == IDLE && start && signal == MULTU;
    last = run && cnt_q == 6'd31;
    sum = prod_q + (mplr_q[0] ? mcand_q : 64'd0);
    state_d = launch ? RUN : last ? IDLE : state_q;
    mcand_d = launch ? {32'd0, in0} : run ? mcand_q << 1 : mcand_q;
    mplr_d = launch ? in1 : run ? mplr_q >> 1 : mplr_q;
    prod_d = launch ? 64'd0 : run ? sum : prod_q;
    cnt_d = launch ? 6'd0 : run ? cnt_q + 6'd1 : cnt_q;
    hi_d = last ? sum[63:32] : hi_q;
    lo_d = last ? sum[31:0] : lo_q;
    done_d = last;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplr_q <= '0;
      prod_q <= '0;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q <= mplr_d;
      prod_q <= prod_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
  assign out = signal == MFHI ? hi_q : signal == MFLO ? lo_q : 32'd0;
endmodule

// File: tb/tb_multu_hilo_32bits.sv
// tb_multu_hilo_32bits: scoreboard bench for the shift-add multiplier
module tb_multu_hilo_32bits;
  localparam logic [5:0] MULTU = 6'b011001, MFHI = 6'b010000, MFLO = 6'b010010, ADD = 6'b100000;
  logic clk = 0, reset = 1, start = 0;
  logic [31:0] in0 = 0, in1 = 0;
  logic [5:0] signal = 0;
  logic busy, done;
  logic [31:0] hi, lo, out;
  logic [63:0] sb[$];
  int errors = 0, checks = 0, done_cnt = 0, snap;
  multu_hilo_32bits dut (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .signal(signal), .start(start),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .out(out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else chk("hilo", {hi, lo}, sb.pop_front());
    end
  end
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    start = 1;
    signal = MULTU;
    in0 = a;
    in1 = b;
    sb.push_back(64'(a) * 64'(b));
    @(posedge clk);
    #1 start = 0;
    signal = 0;
  endtask
  task automatic wait_done(input int exp_cyc);
    int cyc = 0, busy_n = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_n++;
      if (done) break;
    end
    chk("done_lat", 64'(cyc), 64'(exp_cyc));
    chk("busy_cyc", 64'(busy_n), 64'(exp_cyc - 1));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_hilo", {hi, lo}, 0);
    signal = MFHI;
    #1 chk("rst_out", 64'(out), 0);
    reset = 0;
    @(posedge clk);
    #1 launch(3, 5);
    wait_done(33);
    chk("lo_15", 64'(lo), 64'h0F);
    launch(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(33);
    signal = MFHI;
    #1 chk("mfhi_ff", 64'(out), 64'hFFFFFFFE);
    signal = MFLO;
    #1 chk("mflo_ff", 64'(out), 64'h1);
    signal = 0;
    #1 chk("out_other", 64'(out), 0);
    @(negedge clk);
    launch(32'h00010000, 32'h00010000);
    signal = MFHI;
    repeat (5) begin
      @(negedge clk);
      chk("run_old_hi", 64'(out), 64'hFFFFFFFE);
    end
    signal = MFLO;
    #1 chk("run_old_lo", 64'(out), 64'h1);
    wait_done(28);
    chk("new_lo", 64'(out), 0);
    signal = MFHI;
    #1 chk("new_hi", 64'(out), 64'h1);
    launch(32'd123456789, 32'd987654321);
    repeat (9) @(negedge clk);
    start = 1;
    signal = MULTU;
    in0 = 7;
    in1 = 7;
    @(negedge clk);
    start = 0;
    signal = 0;
    wait_done(23);
    launch(5, 6);
    repeat (9) @(negedge clk);
    snap = done_cnt;
    reset = 1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_hilo", {hi, lo}, 0);
    reset = 0;
    sb.delete();
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(snap));
    launch(3, 5);
    wait_done(33);
    start = 1;
    signal = ADD;
    in0 = 9;
    in1 = 9;
    repeat (3) begin
      @(negedge clk);
      chk("add_busy", 64'(busy), 0);
      chk("add_hilo", {hi, lo}, 64'h0F);
      chk("add_out", 64'(out), 0);
    end
    start = 0;
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multu_hilo_32bits.md
MULTU_HILO_32BITS -- requirements
Module: multu_hilo_32bits

Interface
Parameters (name, default, meaning):
REQ-001 SHALL define MULTU, default 6'b011001, function code that launches an unsigned multiply.
REQ-002 SHALL define MFHI, default 6'b010000, function code that selects HI onto out.
REQ-003 SHALL define MFLO, default 6'b010010, function code that selects LO onto out.

Ports (name, direction, width, meaning):
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset, sampled on the rising clk edge.
REQ-006 SHALL have port in0, input, 32, multiplicand, same operand bus as the 32-bit ALU.
REQ-007 SHALL have port in1, input, 32, multiplier, same operand bus as the 32-bit ALU.
REQ-008 SHALL have port signal, input, 6, function code shared with the 32-bit ALU.
REQ-009 SHALL have port start, input, 1, request qualifier; a launch needs start=1 and signal==MULTU.
REQ-010 SHALL have port busy, output, 1, high while a multiply is in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when HI/LO receive a new product.
REQ-012 SHALL have port hi, output, 32, HI register, product[63:32].
REQ-013 SHALL have port lo, output, 32, LO register, product[31:0].
REQ-014 SHALL have port out, output, 32, read-back bus feeding the datapath result mux.

Function
REQ-015 SHALL implement states IDLE and RUN only; reset value is IDLE.
REQ-016 SHALL launch only in IDLE: on a rising edge with start=1 and signal==MULTU, it SHALL load:
- 64-bit multiplicand register = {32'b0, in0}
- 32-bit multiplier register = in1
- 64-bit product accumulator = 0
- 6-bit iteration counter = 0
- busy = 1, state = RUN
REQ-017 SHALL perform one shift-add iteration on each RUN edge:
- if multiplier[0]=1, product += multiplicand (64-bit, no overflow possible)
- multiplicand <<= 1; multiplier >>= 1 (logical)
- counter += 1
REQ-018 SHALL make exactly 32 iterations; on the 32nd RUN edge it SHALL:
- load hi <= final product[63:32] and lo <= final product[31:0]
- set done <= 1, busy <= 0, state <= IDLE
REQ-019 SHALL give latency: launch at edge E0, iterations at E1..E32, done high for exactly the cycle after E32; hi/lo valid in that same cycle.
REQ-020 SHALL hold done at 0 in every cycle other than the cycle after the 32nd iteration.
REQ-021 SHALL ignore start while busy=1: no restart, no operand reload, no change to the in-flight result.
REQ-022 SHALL not launch and SHALL leave all state unchanged when start=1 with signal!=MULTU.
REQ-023 SHALL allow back-to-back operation: a launch is accepted on the edge that ends the done cycle (state IDLE).
REQ-024 SHALL make hi/lo change only at completion (REQ-018) or reset, and SHALL hold them otherwise.
REQ-025 SHALL drive out combinationally:
- hi when signal==MFHI
- lo when signal==MFLO
- 32'h0 for any other code
REQ-026 SHALL return MFHI/MFLO reads during RUN with the previous hi/lo values, never partial products.
REQ-027 SHALL treat operands as unsigned; hi:lo = in0*in1 exactly for all 2^64 operand pairs.

Reset
REQ-028 SHALL, when reset=1 on any edge including mid-RUN:
- set state=IDLE, busy=0, done=0
- clear hi, lo, product, multiplicand, multiplier and counter to 0
- abort any in-flight multiply with no done pulse
REQ-029 SHALL give reset priority over a simultaneous start.

Verification
REQ-030 SHALL cover: launch with in0=3, in1=5 -> busy 1 for 32 cycles; done in cycle 33 after launch; lo=32'h0000000F, hi=32'h0.
REQ-031 SHALL cover: launch with in0=in1=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; then signal=MFHI gives out=32'hFFFFFFFE and signal=MFLO gives out=32'h00000001.
REQ-032 SHALL cover: launch with in0=in1=32'h00010000 -> hi=32'h00000001, lo=32'h0; a prior hi/lo value stays visible on out during RUN until done.
REQ-033 SHALL cover: start pulsed at cycle 10 of RUN with in0=7, in1=7 -> ignored; result equals the first operands.
REQ-034 SHALL cover: reset asserted at RUN cycle 10 -> next cycle busy=0, hi=lo=0, and no done pulse afterwards.
REQ-035 SHALL cover: start=1 with signal=6'b100000 (ADD) -> busy stays 0; hi/lo unchanged.
